// File: rtl/mc_control_seq.sv
// Multi-cycle IF/ID/EX/WB sequencer for a single-issue MIPS datapath (R-type, j, beq).
// Owns pc and IR, generates next-pc, and emits registered wr_enable/retire/illegal strobes.
module mc_control_seq #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [31:0]         inst,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic [5:0]          op_code,
  output logic [4:0]          rd_reg1,
  output logic [4:0]          rd_reg2,
  output logic [4:0]          wr_reg,
  output logic                wr_enable,
  output logic                retire,
  output logic                illegal,
  output logic [31:0]         instr_count,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IF = 2'd0,
    S_ID = 2'd1,
    S_EX = 2'd2,
    S_WB = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         ir_q;
  logic [31:0]         cnt_q;
  logic                wr_en_q;
  logic                retire_q;
  logic                illegal_q;

  logic [PC_WIDTH-1:0] pc_4;
  logic [PC_WIDTH-1:0] br_tgt;
  logic [PC_WIDTH-1:0] j_tgt;
  logic [PC_WIDTH-1:0] ex_pc_d;
  logic [31:0]         cnt_d;
  logic                illegal_d;
  logic [5:0]          op;

  assign op     = ir_q[31:26];
  assign pc_4   = pc_q + PC_WIDTH'(4);
  // Sign-extended word offset; an offset of -1 lands back on pc itself.
  assign br_tgt = pc_4 + {{(PC_WIDTH-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_tgt  = {pc_4[PC_WIDTH-1:28], ir_q[25:0], 2'b00};
  assign cnt_d  = cnt_q + 32'd1;

  always_comb begin
    ex_pc_d   = pc_4;
    illegal_d = 1'b0;
    case (op)
      OP_J:     ex_pc_d = j_tgt;
      OP_BEQ:   ex_pc_d = zero ? br_tgt : pc_4;
      OP_RTYPE: ex_pc_d = pc_4;
      default: begin
        ex_pc_d   = pc_4;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IF;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      cnt_q     <= 32'd0;
      wr_en_q   <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en_q   <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IF: begin
          if (run) begin
            ir_q    <= inst;
            state_q <= S_ID;
          end
        end
        S_ID: state_q <= S_EX;
        S_EX: begin
          if (op == OP_RTYPE) begin
            wr_en_q <= 1'b1;
            state_q <= S_WB;
          end else begin
            pc_q      <= ex_pc_d;
            retire_q  <= 1'b1;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            state_q   <= S_IF;
          end
        end
        S_WB: begin
          pc_q     <= pc_4;
          retire_q <= 1'b1;
          cnt_q    <= cnt_d;
          state_q  <= S_IF;
        end
        default: state_q <= S_IF;
      endcase
    end
  end

  assign pc          = pc_q;
  assign op_code     = ir_q[31:26];
  assign rd_reg1     = ir_q[25:21];
  assign rd_reg2     = ir_q[20:16];
  assign wr_reg      = ir_q[15:11];
  assign wr_enable   = wr_en_q;
  assign retire      = retire_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed plus randomized bench for mc_control_seq against an instruction-level model.
module tb_mc_control_seq;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [31:0] inst;
  logic        zero;
  logic [31:0] pc;
  logic [5:0]  op_code;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic [4:0]  wr_reg;
  logic        wr_enable;
  logic        retire;
  logic        illegal;
  logic [31:0] instr_count;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  // Architectural model state: committed pc and retired-instruction count.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  mc_control_seq #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .inst       (inst),
    .zero       (zero),
    .pc         (pc),
    .op_code    (op_code),
    .rd_reg1    (rd_reg1),
    .rd_reg2    (rd_reg2),
    .wr_reg     (wr_reg),
    .wr_enable  (wr_enable),
    .retire     (retire),
    .illegal    (illegal),
    .instr_count(instr_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_next_pc(input logic [31:0] p, input logic [31:0] w,
                                                input bit z);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = int'($signed(w[15:0]));
    case (w[31:26])
      6'h02:   return {seq[31:28], w[25:0], 2'b00};
      6'h04:   return z ? (seq + 32'(off * 4)) : seq;
      default: return seq;
    endcase
  endfunction

  // Executes one instruction from S_IF to commit, checking every cycle, then idles one cycle.
  task automatic run_instr(input logic [31:0] w, input bit z);
    logic [31:0] npc;
    bit          is_r;
    bit          is_ill;
    is_r   = (w[31:26] == 6'h00);
    is_ill = !(w[31:26] inside {6'h00, 6'h02, 6'h04});
    npc    = model_next_pc(m_pc, w, z);
    chk("pre_state", 32'(state), 32'd0);
    inst = w;
    run  = 1'b1;
    zero = 1'($urandom);
    step();
    run  = 1'($urandom);
    inst = $urandom;
    chk("id_state", 32'(state), 32'd1);
    chk("op_code", 32'(op_code), 32'(w[31:26]));
    chk("rd_reg1", 32'(rd_reg1), 32'(w[25:21]));
    chk("rd_reg2", 32'(rd_reg2), 32'(w[20:16]));
    chk("wr_reg", 32'(wr_reg), 32'(w[15:11]));
    chk("id_retire", 32'(retire), 32'd0);
    chk("id_pc", pc, m_pc);
    zero = ~z;
    step();
    chk("ex_state", 32'(state), 32'd2);
    chk("ex_wr_enable", 32'(wr_enable), 32'd0);
    zero = z;
    if (is_r) begin
      step();
      zero = 1'($urandom);
      chk("wb_state", 32'(state), 32'd3);
      chk("wb_wr_enable", 32'(wr_enable), 32'd1);
      chk("wb_retire", 32'(retire), 32'd0);
      chk("wb_pc", pc, m_pc);
    end
    step();
    m_pc  = npc;
    m_cnt = m_cnt + 32'd1;
    run   = 1'b0;
    chk("commit_state", 32'(state), 32'd0);
    chk("commit_pc", pc, m_pc);
    chk("commit_retire", 32'(retire), 32'd1);
    chk("commit_illegal", 32'(illegal), 32'(is_ill));
    chk("commit_wr_enable", 32'(wr_enable), 32'd0);
    chk("commit_count", instr_count, m_cnt);
    inst = $urandom;
    step();
    chk("idle_retire", 32'(retire), 32'd0);
    chk("idle_illegal", 32'(illegal), 32'd0);
    chk("idle_pc", pc, m_pc);
    chk("idle_state", 32'(state), 32'd0);
  endtask

  // Starts an R-type and pulls reset after `cycles` edges (2 = in S_EX, 3 = in S_WB).
  task automatic reset_mid_rtype(input int cycles, input string tag);
    chk({tag, "_pre_state"}, 32'(state), 32'd0);
    inst = 32'h00221820;
    run  = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    run = 1'b0;
    chk({tag, "_state_before"}, 32'(state), 32'(cycles));
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_wr_enable"}, 32'(wr_enable), 32'd0);
    chk({tag, "_retire"}, 32'(retire), 32'd0);
    chk({tag, "_op_code"}, 32'(op_code), 32'd0);
    #2 reset_n = 1'b1;
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    step();
    chk({tag, "_count"}, instr_count, 32'd0);
    chk({tag, "_post_state"}, 32'(state), 32'd0);
    chk({tag, "_post_pc"}, pc, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [5:0]  op;
    reset_n = 1'b0;
    run     = 1'b0;
    inst    = 32'h0;
    zero    = 1'b0;
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_op_code", 32'(op_code), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_strobes", {29'd0, wr_enable, retire, illegal}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_idle_state", 32'(state), 32'd0);

    run_instr(32'h10210002, 1'b1);   // beq taken: 0 -> 12
    run_instr(32'h10210002, 1'b0);   // beq not taken
    run_instr(32'h08000002, 1'b0);   // j to 8
    run_instr(32'h1000FFFF, 1'b1);   // beq to itself
    run_instr(32'h00221820, 1'b0);   // add $3,$1,$2
    run_instr(32'h08000010, 1'b1);   // j 0x10 -> 0x40
    run_instr(32'hFC000000, 1'b0);   // unsupported opcode

    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inst = $urandom;
      step();
      chk("hold_state", 32'(state), 32'd0);
      chk("hold_pc", pc, m_pc);
    end

    reset_mid_rtype(2, "rst_ex");
    run_instr(32'h1000FFFE, 1'b1);   // branch backwards from 0 wraps to 0xFFFFFFFC
    run_instr(32'h00221820, 1'b0);   // sequential wrap back to 0
    reset_mid_rtype(3, "rst_wb");

    for (int n = 0; n < 150; n++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: op = 6'h00;
        1: op = 6'h02;
        2: op = 6'h04;
        default: begin
          op = 6'($urandom_range(1, 63));
          if (op == 6'h02 || op == 6'h04) op = 6'h3F;
        end
      endcase
      w[31:26] = op;
      run_instr(w, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
